// File: rtl/preg_free_list.sv
// Physical-register free list: circular pool with a commit head and per-ROB-tag
// allocation-pointer checkpoints. Define FREELIST_BYPASS_EN to forward a freed register straight to an empty allocator.
module preg_free_list #(
    parameter int N_PHYS_REGS = 128,
    parameter int N_ARCH_REGS = 32,
    parameter int ROB_DEPTH   = 16,
    localparam int PREG_W     = $clog2(N_PHYS_REGS),
    localparam int ROB_W      = $clog2(ROB_DEPTH),
    localparam int CAP        = N_PHYS_REGS - N_ARCH_REGS,
    localparam int CNT_W      = $clog2(CAP) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              recover_i,
    input  logic [ROB_W-1:0]  recover_tag_i,
    input  logic              checkpoint_take_i,
    input  logic [ROB_W-1:0]  checkpoint_tag_i,
    input  logic              alloc_req_i,
    output logic              alloc_valid_o,
    output logic [PREG_W-1:0] alloc_preg_o,
    output logic              alloc_inval_o,
    input  logic              retire_i,
    input  logic              free_valid_i,
    input  logic [PREG_W-1:0] free_preg_i,
    output logic [CNT_W-1:0]  count_o
);

    // Pointers run modulo 2*CAP so that full and empty are distinguishable.
    localparam int PTR_W = $clog2(2 * CAP);
    localparam int IDX_W = $clog2(CAP);

    logic [PREG_W-1:0] fl   [CAP];
    logic [PTR_W-1:0]  ckpt [ROB_DEPTH];

    logic [PTR_W-1:0] head, tail, chead;
    logic [PTR_W-1:0] head_alloc, head_next, tail_next, chead_next;
    logic [CNT_W-1:0] count;
    logic             full, empty, free_ok;
    logic             alloc_valid, alloc_fire, ckpt_we;
    logic [PREG_W-1:0] alloc_preg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(2 * CAP - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
        return (p >= PTR_W'(CAP)) ? IDX_W'(p - PTR_W'(CAP)) : IDX_W'(p);
    endfunction

    // tail - head modulo 2*CAP; the true difference always fits in PTR_W bits.
    assign count = (tail >= head) ? CNT_W'(tail - head)
                                  : CNT_W'(tail + PTR_W'(2 * CAP) - head);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        full        = (count == CNT_W'(CAP));
        empty       = (count == '0);
        free_ok     = free_valid_i && !full && (free_preg_i != '0);

        alloc_valid = !empty;
        alloc_preg  = fl[ptr_idx(head)];
`ifdef FREELIST_BYPASS_EN
        if (empty && free_ok) begin
            alloc_valid = 1'b1;
            alloc_preg  = free_preg_i;
        end
`endif
        alloc_fire  = !rst && alloc_req_i && alloc_valid && !recover_i && !flush_i;

        head_alloc  = alloc_fire ? ptr_inc(head) : head;
        chead_next  = retire_i ? ptr_inc(chead) : chead;
        tail_next   = free_ok ? ptr_inc(tail) : tail;

        if (recover_i) begin
            head_next = ckpt[recover_tag_i];
        end else if (flush_i) begin
            head_next = chead_next;
        end else begin
            head_next = head_alloc;
        end

        ckpt_we     = checkpoint_take_i && !recover_i && !flush_i;
    end

    assign alloc_valid_o = alloc_valid;
    assign alloc_preg_o  = alloc_preg;
    assign alloc_inval_o = alloc_fire;
    assign count_o       = count;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            chead <= '0;
            tail  <= PTR_W'(CAP);
            // NOTE: the pool contents are architecturally visible after reset, so the array is reset too.
            for (int i = 0; i < CAP; i++) begin
                fl[i] <= PREG_W'(N_ARCH_REGS + i);
            end
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ckpt[i] <= '0;
            end
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            chead <= chead_next;
            if (free_ok) begin
                fl[ptr_idx(tail)] <= free_preg_i;
            end
            // Snapshot includes this cycle's grant so the branch keeps its own destination.
            if (ckpt_we) begin
                ckpt[checkpoint_tag_i] <= head_alloc;
            end
        end
    end

endmodule
